vec_magnitude_seq: RTL and testbench

Sequential Euclidean-magnitude unit: accepts an NCH-component unsigned vector and returns floor(sqrt(sum of squares)) or round-to-nearest(sqrt(sum of squares)), plus an exactness flag. It is the parametrised successor of the team's fixed 8-bit, two-input, free-running magnitude datapath. It adds configurable width and channel count, a valid/ready handshake on both sides, an explicit FSM, and a selectable rounding mode. It sits between the input sampling logic and the output register bank of the top-level tile.

---
 rtl/vec_magnitude_pkg.sv | 26 ++
 rtl/vec_magnitude_isqrt_step.sv | 28 ++
 rtl/vec_magnitude_seq.sv | 156 +++++++++++++++
 tb/tb_vec_magnitude_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_magnitude_pkg.sv
// Shared types and width helpers for the sequential vector-magnitude unit.
package vec_magnitude_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        ROOT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Sum of up to four 2W-bit squares needs two guard bits.
    function automatic int sum_width(input int w);
        return 2 * w + 2;
    endfunction

    // Channel counter: indexes components 0..NCH-1 (at least one bit).
    function automatic int ch_cnt_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Iteration counter: loaded with W and counts down to zero.
    function automatic int iter_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/vec_magnitude_isqrt_step.sv
// One iteration of the restoring digit-by-digit square root.
// The incoming partial root is below 2^W and the incoming remainder is at most
// twice that root, so only W and W+1 bits of them are carried in.
module vec_magnitude_isqrt_step #(
    parameter int W = 8
) (
    input  logic [W:0]   i_rem,
    input  logic [W-1:0] i_root,
    input  logic [1:0]   i_bits,
    output logic [W+2:0] o_rem,
    output logic [W:0]   o_root
);

    logic [W+2:0] w_acc;
    logic [W+2:0] w_trial;
    logic         w_ge;

    assign w_acc   = {i_rem, i_bits};
    assign w_trial = {1'b0, i_root, 2'b01};
    assign w_ge    = (w_acc >= w_trial);

    // Subtract when the trial fits and shift the decision into the root.
    always_comb begin
        o_rem  = w_ge ? (w_acc - w_trial) : w_acc;
        o_root = {i_root, w_ge};
    end

endmodule

// File: rtl/vec_magnitude_seq.sv
// Sequential Euclidean magnitude: squares each component in turn, then
// extracts the integer square root one bit per cycle, with optional
// round-half-up and a perfect-square flag.
//
// state | meaning
// IDLE  | waiting for an input vector, in_ready high
// SQ    | accumulating one component square per cycle
// ROOT  | one square-root bit per cycle, MSB first, W+1 cycles
// DONE  | result presented, waiting for out_ready
module vec_magnitude_seq
    import vec_magnitude_pkg::*;
#(
    parameter int W   = 8,
    parameter int NCH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ena,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [NCH*W-1:0] i_in_data,
    input  logic             i_round_en,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [W:0]       o_out_mag,
    output logic             o_out_exact
);

    localparam int SW = sum_width(W);
    localparam int CW = ch_cnt_width(NCH);
    localparam int IW = iter_cnt_width(W);

    localparam logic [CW-1:0] LAST_CH   = CW'(NCH - 1);
    localparam logic [IW-1:0] ITER_LOAD = IW'(W);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [NCH*W-1:0] r_data;
    logic             r_round;
    logic [SW-1:0]    r_sum;
    logic [CW-1:0]    r_ch;
    logic [IW-1:0]    r_iter;
    logic [W:0]       r_rem;
    logic [W-1:0]     r_root;
    logic [W:0]       r_mag;
    logic             r_exact;

    logic             w_accept;
    logic             w_release;
    logic             w_last_ch;
    logic             w_last_iter;
    logic [W-1:0]     w_comp;
    logic [2*W-1:0]   w_sq;
    logic [W+2:0]     w_rem_nxt;
    logic [W:0]       w_root_nxt;
    logic             w_round_up;

    assign w_accept    = i_ena && i_in_valid && (r_state == IDLE);
    assign w_release   = i_ena && i_out_ready && (r_state == DONE);
    assign w_last_ch   = (r_ch == LAST_CH);
    assign w_last_iter = (r_iter == '0);

    assign w_comp = r_data[int'(r_ch) * W +: W];
    assign w_sq   = w_comp * w_comp;

    // The top two bits of the shifting sum feed each root iteration.
    vec_magnitude_isqrt_step #(
        .W (W)
    ) u_step (
        .i_rem  (r_rem),
        .i_root (r_root),
        .i_bits (r_sum[SW-1 -: 2]),
        .o_rem  (w_rem_nxt),
        .o_root (w_root_nxt)
    );

    // Round half up: bump when the leftover exceeds the floor root.
    assign w_round_up = r_round && (w_rem_nxt > {2'b00, w_root_nxt});

    // Handshake outputs come straight from the state register.
    assign o_in_ready  = (r_state == IDLE);
    assign o_out_valid = (r_state == DONE);
    assign o_out_mag   = r_mag;
    assign o_out_exact = r_exact;

    // State register; ena low freezes the FSM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else if (i_ena) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept)    w_state_nxt = SQ;
            SQ:   if (w_last_ch)   w_state_nxt = ROOT;
            ROOT: if (w_last_iter) w_state_nxt = DONE;
            DONE: if (w_release)   w_state_nxt = IDLE;
            default:               w_state_nxt = IDLE;
        endcase
    end

    // Capture, accumulate, root iteration and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_round <= 1'b0;
            r_sum   <= '0;
            r_ch    <= '0;
            r_iter  <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            r_mag   <= '0;
            r_exact <= 1'b0;
        end else if (i_ena) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data  <= i_in_data;
                        r_round <= i_round_en;
                        r_sum   <= '0;
                        r_ch    <= '0;
                    end
                end
                SQ: begin
                    r_sum <= r_sum + {2'b00, w_sq};
                    r_ch  <= r_ch + CW'(1);
                    if (w_last_ch) begin
                        r_iter <= ITER_LOAD;
                        r_rem  <= '0;
                        r_root <= '0;
                    end
                end
                ROOT: begin
                    // Remainder stays below 2^(W+1) until the final step,
                    // whose full-width result goes only to the outputs.
                    r_rem  <= w_rem_nxt[W:0];
                    r_root <= w_root_nxt[W-1:0];
                    r_sum  <= r_sum << 2;
                    r_iter <= r_iter - IW'(1);
                    if (w_last_iter) begin
                        r_mag   <= w_root_nxt + {{W{1'b0}}, w_round_up};
                        r_exact <= (w_rem_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_magnitude_seq.sv
// Scoreboard bench: expected results are queued at accept time and popped by
// per-DUT monitors whenever a result handshake completes.
module tb_vec_magnitude_seq;

    typedef struct packed {
        logic [31:0] mag;
        logic        exact;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   t_acc_a;
    int   t_acc_b;
    bit   bp_en = 1'b0;

    // DUT A: defaults W=8, NCH=2
    logic        a_ena, a_in_valid, a_in_ready, a_round, a_out_valid, a_out_ready, a_out_exact;
    logic [15:0] a_in_data;
    logic [8:0]  a_out_mag;

    // DUT B: W=4, NCH=4
    logic        b_ena, b_in_valid, b_in_ready, b_round, b_out_valid, b_out_ready, b_out_exact;
    logic [15:0] b_in_data;
    logic [4:0]  b_out_mag;

    vec_magnitude_seq #(.W(8), .NCH(2)) u_dut_a (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ena       (a_ena),
        .i_in_valid  (a_in_valid),
        .o_in_ready  (a_in_ready),
        .i_in_data   (a_in_data),
        .i_round_en  (a_round),
        .o_out_valid (a_out_valid),
        .i_out_ready (a_out_ready),
        .o_out_mag   (a_out_mag),
        .o_out_exact (a_out_exact)
    );

    vec_magnitude_seq #(.W(4), .NCH(4)) u_dut_b (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ena       (b_ena),
        .i_in_valid  (b_in_valid),
        .o_in_ready  (b_in_ready),
        .i_in_data   (b_in_data),
        .i_round_en  (b_round),
        .o_out_valid (b_out_valid),
        .o_out_mag   (b_out_mag),
        .i_out_ready (b_out_ready),
        .o_out_exact (b_out_exact)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference: exact integer sqrt by search, then the rounding rule.
    function automatic exp_t model(input int unsigned c0, input int unsigned c1,
                                   input int unsigned c2, input int unsigned c3,
                                   input bit rnd);
        longint unsigned s;
        longint unsigned r;
        longint unsigned rem;
        exp_t e;
        s = longint'(c0) * c0 + longint'(c1) * c1 + longint'(c2) * c2 + longint'(c3) * c3;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        rem = s - r * r;
        e.mag   = (rnd && rem > r) ? 32'(r + 1) : 32'(r);
        e.exact = (rem == 0);
        return e;
    endfunction

    // Monitor A: score completed handshakes and check hold stability.
    logic       a_hold = 1'b0;
    logic [8:0] a_prev_mag;
    logic       a_prev_exact;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            a_hold = 1'b0;
        end else begin
            if (a_hold) begin
                check("a_hold_valid", a_out_valid, 1);
                check("a_hold_mag", a_out_mag, a_prev_mag);
                check("a_hold_exact", a_out_exact, a_prev_exact);
            end
            if (a_out_valid && a_out_ready && a_ena) begin
                if (qa.size() == 0) begin
                    timeout_fail("a_unexpected_result");
                end else begin
                    e = qa.pop_front();
                    check("a_mag", a_out_mag, e.mag);
                    check("a_exact", a_out_exact, e.exact);
                end
            end
            a_hold       = a_out_valid && !(a_out_ready && a_ena);
            a_prev_mag   = a_out_mag;
            a_prev_exact = a_out_exact;
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_out_valid && b_out_ready && b_ena) begin
            if (qb.size() == 0) begin
                timeout_fail("b_unexpected_result");
            end else begin
                e = qb.pop_front();
                check("b_mag", b_out_mag, e.mag);
                check("b_exact", b_out_exact, e.exact);
            end
        end
    end

    // Random backpressure on A's consumer.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) a_out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue_a(input int unsigned c0, input int unsigned c1, input bit rnd);
        int guard = 0;
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = {8'(c1), 8'(c0)};
        a_round    = rnd;
        while (!(a_in_ready && a_ena) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            timeout_fail("a_accept");
            a_in_valid = 1'b0;
            return;
        end
        qa.push_back(model(c0, c1, 0, 0, rnd));
        @(posedge clk);
        #1;
        t_acc_a    = cyc;
        a_in_valid = 1'b0;
    endtask

    task automatic wait_valid_a(output int lat, input bit chk_rdy);
        int guard = 0;
        while (!a_out_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
            if (chk_rdy && !a_out_valid) check("a_busy_in_ready", a_in_ready, 0);
        end
        if (!a_out_valid) timeout_fail("a_valid");
        lat = cyc - t_acc_a;
    endtask

    task automatic wait_idle_a();
        int guard = 0;
        while (!a_in_ready && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!a_in_ready) timeout_fail("a_idle");
    endtask

    task automatic run_b(input int unsigned c0, input int unsigned c1,
                         input int unsigned c2, input int unsigned c3, input bit rnd);
        int guard = 0;
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
        b_round    = rnd;
        while (!b_in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            timeout_fail("b_accept");
            b_in_valid = 1'b0;
            return;
        end
        qb.push_back(model(c0, c1, c2, c3, rnd));
        @(posedge clk);
        #1;
        t_acc_b    = cyc;
        b_in_valid = 1'b0;
        guard      = 0;
        while (!b_out_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!b_out_valid) timeout_fail("b_valid");
        else check("b_latency", cyc - t_acc_b, 9);
    endtask

    initial begin
        int lat;
        rst_n      = 1'b0;
        a_ena      = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_round = 1'b0; a_out_ready = 1'b1;
        b_ena      = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_round = 1'b0; b_out_ready = 1'b1;

        #12;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_mag", a_out_mag, 0);
        check("rst_out_exact", a_out_exact, 0);
        check("rst_b_in_ready", b_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // (3,4) floor: exact 5, latency 11, busy throughout.
        issue_a(3, 4, 0);
        wait_valid_a(lat, 1);
        check("lat_3_4", lat, 11);
        wait_idle_a();

        // Boundary and rounding vectors.
        issue_a(255, 255, 0); wait_valid_a(lat, 0); check("lat_255", lat, 11);
        issue_a(255, 255, 1); wait_valid_a(lat, 0);
        issue_a(12, 13, 1);   wait_valid_a(lat, 0);
        issue_a(12, 13, 0);   wait_valid_a(lat, 0);
        issue_a(1, 1, 1);     wait_valid_a(lat, 0);
        issue_a(0, 0, 0);     wait_valid_a(lat, 0);
        wait_idle_a();

        // (5,5) held by out_ready low; a stray in_valid must be ignored.
        a_out_ready = 1'b0;
        issue_a(5, 5, 0);
        wait_valid_a(lat, 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("hold_in_ready", a_in_ready, 0);
            check("hold_out_valid", a_out_valid, 1);
            check("hold_out_mag", a_out_mag, 7);
            if (i == 5) begin
                a_in_valid = 1'b1;
                a_in_data  = {8'd9, 8'd9};
            end
            if (i == 6) a_in_valid = 1'b0;
        end
        a_out_ready = 1'b1;
        wait_idle_a();

        // Asynchronous reset in the middle of ROOT discards the operation.
        issue_a(200, 100, 0);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", a_out_valid, 0);
        check("arst_in_ready", a_in_ready, 1);
        check("arst_out_mag", a_out_mag, 0);
        check("arst_out_exact", a_out_exact, 0);
        qa.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        issue_a(6, 8, 0);
        wait_valid_a(lat, 0);
        check("lat_after_rst", lat, 11);
        wait_idle_a();

        // ena low for 5 cycles during SQ stretches latency by 5.
        issue_a(7, 9, 1);
        @(posedge clk);
        #1;
        a_ena = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        a_ena = 1'b1;
        wait_valid_a(lat, 0);
        check("lat_ena_stall", lat, 16);
        wait_idle_a();

        // Random vectors under random backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int unsigned c0, c1;
            c0 = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
            c1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
            issue_a(c0, c1, 1'($urandom_range(0, 1)));
            wait_valid_a(lat, 0);
            check("lat_rand", lat, 11);
        end
        bp_en = 1'b0;
        @(posedge clk);
        #2;
        a_out_ready = 1'b1;
        wait_idle_a();

        // Wide/short configuration: W=4, NCH=4.
        run_b(15, 15, 15, 15, 0);
        for (int i = 0; i < 8; i++) begin
            run_b($urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end
        repeat (3) @(posedge clk);
        #1;

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
